// File: rtl/aes_pkg.sv
// Shared AES types and constants for the round sequencer slice.
package aes_pkg;

    typedef logic [3:0][3:0][7:0] state_t;

    localparam int unsigned AES128_NR = 10;
    localparam int unsigned AES192_NR = 12;
    localparam int unsigned AES256_NR = 14;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } seq_state_e;

    // A latency of 1 still needs a 1-bit counter that simply stays at zero.
    function automatic int unsigned cnt_width(input int unsigned lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/aes_round_timer.sv
// Cycle-within-round and round-number counters for the AES round sequencer.
module aes_round_timer
    import aes_pkg::*;
#(
    parameter int unsigned NR        = AES128_NR,
    parameter int unsigned ROUND_LAT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic       run_i,
    output logic [3:0] round_o,
    output logic       round_done_o,
    output logic       last_round_o
);

    localparam int unsigned    CW         = cnt_width(ROUND_LAT);
    localparam logic [CW-1:0]  CNT_LAST   = CW'(ROUND_LAT - 1);
    localparam logic [3:0]     ROUND_LAST = 4'(NR);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    round_q, round_d;

    assign round_o      = round_q;
    assign round_done_o = (cnt_q == CNT_LAST);
    assign last_round_o = (round_q == ROUND_LAST);

    // The round number saturates at NR; leaving the last round is the FSM's job.
    always_comb begin
        cnt_d   = cnt_q;
        round_d = round_q;
        if (load_i) begin
            cnt_d   = '0;
            round_d = 4'd1;
        end else if (run_i) begin
            if (round_done_o) begin
                cnt_d = '0;
                if (!last_round_o) begin
                    round_d = round_q + 4'd1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            round_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            round_q <= round_d;
        end
    end

endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES controller: initial AddRoundKey, NR passes through an external
// round datapath with fixed latency, then presents the ciphertext on valid/ready.
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int unsigned NR        = AES128_NR,
    parameter int unsigned ROUND_LAT = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_block,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk,
    output logic         dp_en,
    output logic         dp_last,
    output logic [127:0] dp_state,
    output logic [127:0] dp_key,
    input  logic [127:0] dp_new_state
);

    seq_state_e state_q, state_d;
    state_t     st_q, st_d;

    logic [3:0] round;
    logic       round_done;
    logic       last_round;
    logic       tmr_load;
    logic       tmr_run;

    assign tmr_load = (state_q == IDLE) && in_valid;
    assign tmr_run  = (state_q == RUN);

    aes_round_timer #(
        .NR        (NR),
        .ROUND_LAT (ROUND_LAT)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .load_i       (tmr_load),
        .run_i        (tmr_run),
        .round_o      (round),
        .round_done_o (round_done),
        .last_round_o (last_round)
    );

    // st_q feeds the datapath for the whole round and only updates on its last cycle.
    assign dp_state  = st_q;
    assign dp_key    = rk;
    assign out_block = st_q;

    always_comb begin
        state_d   = state_q;
        st_d      = st_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        rk_idx    = 4'd0;
        dp_en     = 1'b0;
        dp_last   = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    st_d    = in_block ^ rk;
                    state_d = RUN;
                end
            end
            RUN: begin
                rk_idx  = round;
                dp_en   = 1'b1;
                dp_last = last_round;
                if (round_done) begin
                    st_d = dp_new_state;
                    if (last_round) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            st_q    <= '0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
        end
    end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench for aes_round_sequencer: AES-128 vectors through a latency-modelled
// round datapath, stub-datapath sequencing checks, and an NR=14/ROUND_LAT=1 instance.
module tb_aes_round_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [127:0] in_block, out_block;
    logic [3:0]   rk_idx;
    logic [127:0] rk, dp_state, dp_key, dp_new_state;
    logic         dp_en, dp_last;

    logic         in_valid2, in_ready2, out_valid2, out_ready2;
    logic [127:0] in_block2, out_block2;
    logic [3:0]   rk_idx2;
    logic [127:0] rk2, dp_state2, dp_key2, dp_new_state2;
    logic         dp_en2, dp_last2;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // ---------------- AES reference arithmetic ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p ^= x;
            x = xt(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x};
        return d[15-n -: 8];
    endfunction

    // Multiplicative inverse as b^254, then the FIPS-197 affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] inv, base, e;
        inv = 8'h01; base = b; e = 8'd254;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) inv = gmul(inv, base);
            base = gmul(base, base);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[4*c+r] = b[4*((c+r)%4)+r];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
        end
        o = '0;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
        return o ^ k;
    endfunction

    logic         real_dp;
    logic [127:0] rk_tab [16];

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox(tmp[31:24]), sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0])};
                tmp = tmp ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] ref_cipher(input logic [127:0] pt, input int nr);
        logic [127:0] s;
        s = pt ^ rk_tab[0];
        for (int r = 1; r <= nr; r++) s = aes_round(s, rk_tab[r], r == nr);
        return s;
    endfunction

    // ---------------- datapath models ----------------
    assign rk = real_dp ? rk_tab[rk_idx] : '0;

    logic [127:0] pipe0, pipe1, pipe2;
    always @(posedge clk) begin
        pipe0 <= real_dp ? aes_round(dp_state, dp_key, dp_last) : dp_state + 128'd1;
        pipe1 <= pipe0;
        pipe2 <= pipe1;
    end
    assign dp_new_state = pipe2;

    assign rk2           = '0;
    assign dp_new_state2 = dp_state2 + 128'd1;

    aes_round_sequencer #(.NR(10), .ROUND_LAT(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
        .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
        .rk_idx(rk_idx), .rk(rk),
        .dp_en(dp_en), .dp_last(dp_last), .dp_state(dp_state), .dp_key(dp_key),
        .dp_new_state(dp_new_state)
    );

    aes_round_sequencer #(.NR(14), .ROUND_LAT(1)) dut14 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_block(in_block2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_block(out_block2),
        .rk_idx(rk_idx2), .rk(rk2),
        .dp_en(dp_en2), .dp_last(dp_last2), .dp_state(dp_state2), .dp_key(dp_key2),
        .dp_new_state(dp_new_state2)
    );

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: got timeout required event", name);
    endtask

    logic [3:0] tr_idx [$];
    logic       tr_last [$];
    int         key_bad;

    // Drive one block, record rk_idx/dp_last per cycle, return result and latency in cycles.
    task automatic run_block(input logic [127:0] pt, input bit random_ready,
                             output logic [127:0] ct, output int lat);
        int w;
        int stable;
        logic [127:0] first;
        ct = '0; lat = -1;
        in_block = pt; in_valid = 1'b1; w = 0;
        while (!in_ready && w < 20) begin @(negedge clk); w++; end
        if (!in_ready) begin
            fail_timeout("accept");
            in_valid = 1'b0;
            return;
        end
        tr_idx.delete(); tr_last.delete(); key_bad = 0;
        tr_idx.push_back(rk_idx); tr_last.push_back(dp_last);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 300) begin
            tr_idx.push_back(rk_idx); tr_last.push_back(dp_last);
            if (dp_key !== rk) key_bad++;
            @(negedge clk);
            lat++;
        end
        tr_idx.push_back(rk_idx); tr_last.push_back(dp_last);
        if (!out_valid) begin
            fail_timeout("out_valid");
            lat = -1;
            return;
        end
        first = out_block; stable = 1; w = 0;
        forever begin
            out_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (w >= 8) out_ready = 1'b1;
            if (out_block !== first || !out_valid || in_ready) stable = 0;
            if (out_ready) begin
                ct = out_block;
                @(negedge clk);
                out_ready = 1'b0;
                break;
            end
            @(negedge clk);
            w++;
        end
        chk_int("out_hold_stable", stable, 1);
    endtask

    typedef struct {
        bit           real_dp;
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] exp_ct;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #1000000;
        $display("FAIL watchdog: got time limit required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] ct, exp;
        int lat, bad_idx, bad_last, n_last, w, seen, bp_bad;
        int acc [$];
        logic [127:0] outs [$];
        int max_idx, key2_bad;

        rst = 1'b1; in_valid = 1'b0; in_block = '0; out_ready = 1'b0; real_dp = 1'b0;
        in_valid2 = 1'b0; in_block2 = '0; out_ready2 = 1'b0;
        for (int i = 0; i < 16; i++) rk_tab[i] = '0;

        vecs[0].real_dp = 1'b1;
        vecs[0].key     = 128'h000102030405060708090a0b0c0d0e0f;
        vecs[0].pt      = 128'h00112233445566778899aabbccddeeff;
        vecs[0].exp_ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        vecs[1].real_dp = 1'b1;
        vecs[1].key     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        vecs[1].pt      = 128'h3243f6a8885a308d313198a2e0370734;
        vecs[1].exp_ct  = 128'h3925841d02dc09fbdc118597196a0b32;
        vecs[2].real_dp = 1'b0; vecs[2].key = '0;
        vecs[2].pt      = '0;
        vecs[2].exp_ct  = 128'h0a;
        vecs[3].real_dp = 1'b0; vecs[3].key = '0;
        vecs[3].pt      = '1;
        vecs[3].exp_ct  = 128'h09;
        vecs[4].real_dp = 1'b0; vecs[4].key = '0;
        vecs[4].pt      = 128'hffffffff_ffffffff_ffffffff_fffffff6;
        vecs[4].exp_ct  = 128'h0;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_dp_en", 128'(dp_en), 128'd0);
        chk("rst_dp_last", 128'(dp_last), 128'd0);
        chk("rst_rk_idx", 128'(rk_idx), 128'd0);
        chk("rst_dp_state", dp_state, 128'd0);
        chk("rst_in_ready_nr14", 128'(in_ready2), 128'd1);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            real_dp = vecs[i].real_dp;
            if (vecs[i].real_dp) expand_key(vecs[i].key);
            run_block(vecs[i].pt, 1'b0, ct, lat);
            chk($sformatf("vec%0d_ct", i), ct, vecs[i].exp_ct);
            chk_int($sformatf("vec%0d_latency", i), lat, 41);
        end

        // Random round-key tables and plaintexts with random output stalls.
        real_dp = 1'b1;
        for (int n = 0; n < 6; n++) begin
            for (int r = 0; r < 11; r++) rk_tab[r] = {$urandom, $urandom, $urandom, $urandom};
            exp = ref_cipher({$urandom, $urandom, $urandom, $urandom}, 10);
            run_block(rk_tab[15] ^ '0, 1'b1, ct, lat);
            exp = ref_cipher(rk_tab[15], 10);
            chk($sformatf("rand%0d_ct", n), ct, exp);
            chk_int($sformatf("rand%0d_latency", n), lat, 41);
            rk_tab[15] = {$urandom, $urandom, $urandom, $urandom};
        end

        // Round-key index and final-round flag per cycle with the stub datapath.
        real_dp = 1'b0;
        run_block('0, 1'b0, ct, lat);
        chk("trace_ct", ct, 128'h0a);
        chk_int("trace_len", tr_idx.size(), 42);
        bad_idx = 0; bad_last = 0; n_last = 0;
        for (int k = 0; k < tr_idx.size(); k++) begin
            if (int'(tr_idx[k]) != ((k == 0 || k >= 41) ? 0 : (k - 1) / 4 + 1)) bad_idx++;
            if (tr_last[k] !== ((k >= 37 && k <= 40) ? 1'b1 : 1'b0)) bad_last++;
            if (tr_last[k] === 1'b1) n_last++;
        end
        chk_int("rk_idx_sequence_errors", bad_idx, 0);
        chk_int("dp_last_sequence_errors", bad_last, 0);
        chk_int("dp_last_cycles", n_last, 4);
        chk_int("dp_key_vs_rk_errors", key_bad, 0);

        // Backpressure: 20 stalled cycles with a competing in_valid held high.
        in_block = 128'd5; in_valid = 1'b1;
        @(negedge clk);
        in_block = 128'hdead; w = 0;
        while (!out_valid && w < 100) begin @(negedge clk); w++; end
        if (!out_valid) fail_timeout("bp_out_valid");
        bp_bad = 0;
        for (int k = 0; k < 20; k++) begin
            if (!out_valid || in_ready || out_block !== 128'd15) bp_bad++;
            @(negedge clk);
        end
        chk_int("backpressure_errors", bp_bad, 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b0;
        chk("bp_release_in_ready", 128'(in_ready), 128'd1);
        chk("bp_release_out_valid", 128'(out_valid), 128'd0);

        // Reset in the middle of a block.
        in_block = '0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_in_ready", 128'(in_ready), 128'd1);
        chk("midrst_dp_en", 128'(dp_en), 128'd0);
        chk("midrst_rk_idx", 128'(rk_idx), 128'd0);
        seen = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 50; k++) begin
            if (out_valid) seen++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        chk_int("midrst_spurious_out_valid", seen, 0);
        run_block(128'd7, 1'b0, ct, lat);
        chk("midrst_next_ct", ct, 128'h11);
        chk_int("midrst_next_latency", lat, 41);

        // in_valid held continuously: one accept every 42 cycles.
        in_block = '0; in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 126; k++) begin
            if (in_valid && in_ready) acc.push_back(k);
            if (out_valid && out_ready) outs.push_back(out_block);
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk_int("stream_accepts", acc.size(), 3);
        chk_int("stream_outputs", outs.size(), 3);
        for (int i = 0; i < acc.size() && i < 3; i++)
            chk_int($sformatf("stream_accept%0d_cycle", i), acc[i], 42 * i);
        for (int i = 0; i < outs.size() && i < 3; i++)
            chk($sformatf("stream_out%0d", i), outs[i], 128'h0a);

        // NR=14, ROUND_LAT=1 instance.
        in_block2 = '0; in_valid2 = 1'b1;
        chk("nr14_in_ready", 128'(in_ready2), 128'd1);
        @(negedge clk);
        in_valid2 = 1'b0;
        lat = 1; n_last = 0; max_idx = 0; key2_bad = 0;
        while (!out_valid2 && lat < 100) begin
            if (dp_last2) n_last++;
            if (int'(rk_idx2) > max_idx) max_idx = int'(rk_idx2);
            if (!dp_en2 || dp_key2 !== '0) key2_bad++;
            @(negedge clk);
            lat++;
        end
        if (!out_valid2) fail_timeout("nr14_out_valid");
        chk_int("nr14_latency", lat, 15);
        chk("nr14_ct", out_block2, 128'h0e);
        chk_int("nr14_dp_last_cycles", n_last, 1);
        chk_int("nr14_max_rk_idx", max_idx, 14);
        chk_int("nr14_dp_en_key_errors", key2_bad, 0);
        out_ready2 = 1'b1;
        @(negedge clk);
        out_ready2 = 1'b0;
        chk("nr14_back_idle", 128'(in_ready2), 128'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
